// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    // Framer states: line idle, start bit, eight data bits, stop bit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // 100 MHz system clock at 9600 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 10417;

    // Start bit + 8 data bits + stop bit.
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the wrap cycle.
// tick is a flop that is high exactly while the counter holds its last value,
// so the framer sees a glitch-free "last cycle of this bit" marker.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CountW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CountW-1:0] LastCount = CountW'(CLKS_PER_BIT - 1);
    localparam logic [CountW-1:0] PreLastCount = CountW'(CLKS_PER_BIT - 2);

    logic [CountW-1:0] count;

    // Free-running bit counter, held at zero while restart is high; tick is
    // precomputed one cycle ahead so it lines up with the wrap cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (restart) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= (count == PreLastCount);
            if (count == LastCount) begin
                count <= '0;
            end else begin
                count <= count + CountW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// 8N1 UART transmitter, LSB first, with a one-entry holding register so a
// request arriving mid-frame is sent back-to-back with no idle gap.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    tx_state_t  state;
    logic [7:0] shiftReg;
    logic [7:0] pendData;
    logic       pendValid;
    logic [2:0] bitIndex;
    logic       txReg;
    logic       busyReg;
    logic       overflowReg;
    logic       tick;
    logic       restart;
    logic       stopEnd;

    // The bit timer sits at zero while idle, so the first start-bit cycle
    // always sees a fresh count; every other state entry happens on a wrap.
    assign restart = (state == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) baudGen (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    // Last cycle of the stop bit; both terms are flops, so done has no path
    // from any input.
    assign stopEnd = (state == STOP) && tick;

    assign tx       = txReg;
    assign busy     = busyReg;
    assign done     = stopEnd;
    assign overflow = overflowReg;

    // Framer FSM with shift register, holding register and registered line outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shiftReg    <= '0;
            pendData    <= '0;
            pendValid   <= 1'b0;
            bitIndex    <= '0;
            txReg       <= 1'b1;
            busyReg     <= 1'b0;
            overflowReg <= 1'b0;
        end else begin
            overflowReg <= 1'b0;

            // Requests while a frame is in flight go to the holding register.
            // At the stop bit's final cycle with the holder empty, the byte is
            // loaded straight into the shifter by the STOP branch instead.
            if (send && (state != IDLE)) begin
                if (pendValid) begin
                    overflowReg <= 1'b1;
                end else if (!stopEnd) begin
                    pendValid <= 1'b1;
                    pendData  <= data;
                end
            end

            case (state)
                IDLE: begin
                    if (send) begin
                        shiftReg <= data;
                        state    <= START;
                        txReg    <= 1'b0;
                        busyReg  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state    <= DATA;
                        bitIndex <= '0;
                        txReg    <= shiftReg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shiftReg <= {1'b0, shiftReg[7:1]};
                        bitIndex <= bitIndex + 3'd1;
                        if (bitIndex == 3'd7) begin
                            state <= STOP;
                            txReg <= 1'b1;
                        end else begin
                            txReg <= shiftReg[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (pendValid) begin
                            shiftReg  <= pendData;
                            pendValid <= 1'b0;
                            state     <= START;
                            txReg     <= 1'b0;
                        end else if (send) begin
                            shiftReg <= data;
                            state    <= START;
                            txReg    <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            busyReg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Serialises one byte per request onto the board's UART TX line as an 8N1 frame, LSB first. Sits directly downstream of the button debouncer: the debouncer's single-cycle press pulse drives `send`, and the byte on the switches is transmitted to the host. A one-entry holding register absorbs a press that arrives mid-frame, so the next frame follows with no idle gap.

## Interface
- `CLKS_PER_BIT`, default 10417: clock cycles per bit (100 MHz / 9600 baud); legal range ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `send`  in  1  request; one-cycle pulse from the debouncer.
- `data`  in  8  byte to transmit; sampled only in the cycle `send` is high.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is in flight.
- `done`  out  1  one-cycle pulse on the last cycle of each stop bit.
- `overflow`  out  1  one-cycle pulse when a request is dropped.

## Operation
- Reset: `tx`=1, `busy`=0, `done`=0, `overflow`=0. State is IDLE, counters are 0 and the pending register is empty. Reset asserted mid-frame aborts the frame immediately; `tx` returns high asynchronously.
- States: IDLE, START, DATA, STOP.
- IDLE: `send` loads `data` into the shift register and moves to START.
- START: drive 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA: drive shift[0] for `CLKS_PER_BIT` cycles, shift right, increment the index. After index 7 completes, go to STOP.
- STOP: drive 1 for `CLKS_PER_BIT` cycles and pulse `done` on the last cycle. Then:
  - if pending is valid, load it into the shift register, clear pending and go to START;
  - otherwise go to IDLE.
- Baud counter runs 0..`CLKS_PER_BIT`-1. The bit advances on the wrap, and the counter clears on every state entry.
- `send` while not IDLE and pending empty: capture `data` into pending.
- `send` while pending full: request dropped, pending unchanged, `overflow` pulses the following cycle.
- `send` in the same cycle as STOP's final cycle with pending empty: captured into pending, and the transmitter goes to START. The request is not lost and not treated as overflow.
- `send` in the same cycle as STOP's final cycle with pending full: the pending byte is transmitted, the new request drops and `overflow` pulses.
- `data` changes after capture do not affect the frame.

## Timing
- `send` high at cycle N (in IDLE) → `tx` low and `busy` high from cycle N+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles: start, 8 data bits, stop.
- `done` is high in cycle N+10×`CLKS_PER_BIT`.
- Without pending: `busy` falls at cycle N+10×`CLKS_PER_BIT`+1.
- With pending: the next start bit begins at cycle N+10×`CLKS_PER_BIT`+1, and `busy` stays high continuously.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Bit index is 3 bits. The baud counter is $clog2(`CLKS_PER_BIT`) bits and never exceeds `CLKS_PER_BIT`-1.

## Structure
- Shared package `uart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, STOP);
  - `DEFAULT_CLKS_PER_BIT` = 10417;
  - `FRAME_BITS` = 10.
- One sub-module: `uart_baud_gen`. It takes `CLKS_PER_BIT` as a parameter, has inputs `clk`, `reset` and `restart`, and outputs a one-cycle `tick` on each counter wrap.
- The framer FSM, shift register and pending register live in `uart_tx_framer`.

## Test plan
Benches use `CLKS_PER_BIT`=4.
- Reset then idle 20 cycles → `tx`=1, `busy`=0, `done`=0, `overflow`=0 throughout.
- `send` with `data`=8'hA5 at cycle N → `tx` levels per 4-cycle bit from N+1 are 0,1,0,1,0,0,1,0,1,1. `done` pulses at N+40 and `busy` falls at N+41.
- 8'h3C sent, then `send` with 8'hFF at N+10 → first frame completes at N+40. Start bit of 8'hFF at N+41, `busy` never drops, second `done` at N+80.
- Three sends at N, N+5 and N+9 (0x11, 0x22, 0x33) → 0x11 and 0x22 transmitted back-to-back. `overflow` pulses at N+10 and 0x33 never appears.
- `send` 0x55 exactly at STOP's final cycle (N+40) of a 0x00 frame → 0x55 frame starts at N+41 and `overflow` stays 0.
- `reset` asserted at N+17 mid-frame → `tx`=1 and `busy`=0 immediately. After release, a fresh `send` of 0x81 produces a correct full frame.
